// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs and pipeline-register controls for pipeline_ctrl
interface pipeline_ctrl_if;
    logic       m_mem_req;
    logic       dmem_ready;
    logic       imem_ready;
    logic       m_take_branch;
    logic       ex_is_load;
    logic [4:0] ex_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs2;
    logic       pc_write;
    logic       pc_sel_branch;
    logic       write_fd;
    logic       write_de;
    logic       write_em;
    logic       write_mw;
    logic       flush_fd;
    logic       flush_de;
    logic       flush_em;
    logic       flush_mw;

    modport master (
        input  m_mem_req, dmem_ready, imem_ready, m_take_branch,
               ex_is_load, ex_rd, id_rs1, id_rs2, id_uses_rs2,
        output pc_write, pc_sel_branch,
               write_fd, write_de, write_em, write_mw,
               flush_fd, flush_de, flush_em, flush_mw
    );

    modport slave (
        output m_mem_req, dmem_ready, imem_ready, m_take_branch,
               ex_is_load, ex_rd, id_rs1, id_rs2, id_uses_rs2,
        input  pc_write, pc_sel_branch,
               write_fd, write_de, write_em, write_mw,
               flush_fd, flush_de, flush_em, flush_mw
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - prioritized stall/flush sequencer with front-end fetch FSM
module pipeline_ctrl (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_ctrl_if.master        bus,
    output logic [31:0]            stall_cycles,
    output logic [31:0]            flush_count
);
    typedef enum logic [1:0] {RUN, IWAIT, IDROP} fe_state_t;

    fe_state_t   state, state_nxt;
    logic [31:0] stall_cnt, flush_cnt;
    logic        pc_write_c, pc_sel_c, flush_inc;
    logic        wfd, wde, wem, wmw, ffd, fde, fem, fmw;
    logic        d_stall, load_use;

    assign d_stall  = bus.m_mem_req && !bus.dmem_ready;
    assign load_use = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                      ((bus.ex_rd == bus.id_rs1) ||
                       (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            state <= state_nxt;
            if (!pc_write_c)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush_inc)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

    always_comb begin
        pc_write_c = 1'b1;
        pc_sel_c   = 1'b0;
        flush_inc  = 1'b0;
        wfd = 1'b1; wde = 1'b1; wem = 1'b1; wmw = 1'b1;
        ffd = 1'b0; fde = 1'b0; fem = 1'b0; fmw = 1'b0;
        state_nxt  = state;

        // A returning fetch always releases IWAIT/IDROP, even under a D-stall.
        case (state)
            RUN:     if (!bus.imem_ready && !d_stall) state_nxt = IWAIT;
            IWAIT:   if (bus.imem_ready) state_nxt = RUN;
            IDROP:   if (bus.imem_ready) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase

        if (d_stall) begin
            pc_write_c = 1'b0;
            wfd = 1'b0; wde = 1'b0; wem = 1'b0;
            fmw = 1'b1;
        end else if (bus.m_take_branch) begin
            pc_sel_c  = 1'b1;
            flush_inc = 1'b1;
            ffd = 1'b1; fde = 1'b1; fem = 1'b1;
            // Any fetch still in flight belongs to the wrong path.
            if (state == IDROP || !bus.imem_ready)
                state_nxt = IDROP;
            else
                state_nxt = RUN;
        end else if (load_use) begin
            pc_write_c = 1'b0;
            wfd = 1'b0;
            fde = 1'b1;
        end else if (state == IDROP || !bus.imem_ready) begin
            pc_write_c = 1'b0;
            ffd = 1'b1;
        end
    end

    assign bus.pc_write      = pc_write_c & ~reset;
    assign bus.pc_sel_branch = pc_sel_c   & ~reset;
    assign bus.write_fd      = wfd & ~reset;
    assign bus.write_de      = wde & ~reset;
    assign bus.write_em      = wem & ~reset;
    assign bus.write_mw      = wmw & ~reset;
    assign bus.flush_fd      = ffd & ~reset;
    assign bus.flush_de      = fde & ~reset;
    assign bus.flush_em      = fem & ~reset;
    assign bus.flush_mw      = fmw & ~reset;
    assign stall_cycles      = stall_cnt;
    assign flush_count       = flush_cnt;
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It drives the `write` enable and bubble (flush) inputs of the F/D, D/E, E/M and M/W pipeline registers and the PC, which makes the hazard rules explicit in one place. It resolves four hazards in strict priority: data-memory wait, taken branch in M, load-use, and instruction-fetch wait. A small front-end FSM tracks outstanding and wrong-path fetches, and two counters record stall and flush activity.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- m_mem_req  in  1  instruction in M accesses data memory.
- dmem_ready  in  1  data-memory access completes this cycle.
- imem_ready  in  1  fetched word valid; held high by memory until consumed (pc_write=1 or discarded in IDROP).
- m_take_branch  in  1  ALU_take_branch from the E/M register.
- ex_is_load  in  1  instruction in E is a load.
- ex_rd  in  5  destination index of instruction in E.
- id_rs1, id_rs2  in  5 each  source indices of instruction in D.
- id_uses_rs2  in  1  D instruction reads rs2.
- pc_write  out  1  PC load enable.
- pc_sel_branch  out  1  PC mux selects branch target.
- write_fd, write_de, write_em, write_mw  out  1 each  pipeline register write enables.
- flush_fd, flush_de, flush_em, flush_mw  out  1 each  load zeros (bubble); asserted only together with the matching write.
- stall_cycles  out  32  count of cycles with pc_write=0.
- flush_count  out  32  count of branch flushes.

## Operation
- Front-end FSM states: RUN, IWAIT (fetch outstanding), IDROP (wrong-path fetch being discarded).
- Outputs are combinational from state and inputs (Mealy). State and counters are registered.
- Default cycle: all write_*=1, all flush_*=0, pc_write=1, pc_sel_branch=0.
- Rules are evaluated in priority order. The first matching rule sets the outputs.
- P1, D-stall (m_mem_req && !dmem_ready):
  - pc_write, write_fd, write_de and write_em are 0.
  - write_mw=1 and flush_mw=1.
  - All lower-priority rules are ignored.
- P2, branch (m_take_branch):
  - pc_write=1 and pc_sel_branch=1.
  - flush_fd, flush_de and flush_em are 1, with their writes at 1.
  - flush_count increments.
  - If imem_ready=0, the next state is IDROP; otherwise it is RUN.
- P3, load-use (ex_is_load && ex_rd!=0 && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2))):
  - pc_write=0 and write_fd=0.
  - flush_de=1.
  - E/M and M/W advance.
- P4, fetch wait (state IDROP, or imem_ready=0):
  - pc_write=0.
  - flush_fd=1.
  - D/E, E/M and M/W advance.
- FSM transitions:
  - RUN→IWAIT when imem_ready=0 and P1/P2 do not apply.
  - IWAIT→RUN when imem_ready=1.
  - IDROP→RUN when imem_ready=1, evaluated even during P1; the word is discarded.
  - P2 overrides IWAIT (→IDROP or RUN as above).
  - In IDROP, P2 is a new redirect: the state stays in IDROP.
- stall_cycles increments every cycle pc_write=0, including P1, P3 and P4.
- Both counters wrap modulo 2^32.
- ex_rd==0 never causes a load-use stall.

## Timing
- Reset (asynchronous, immediate):
  - state=RUN and both counters 0.
  - While reset is high, all write_*, flush_*, pc_write and pc_sel_branch are forced to 0.
- Outputs are valid in the same cycle as their inputs; there is zero added latency.
- The D-stall releases in the cycle dmem_ready=1, which is evaluated as a normal cycle.
- A load-use stall lasts exactly 1 cycle: the bubble moves the load to M, so the comparison clears.
- A branch costs 3 bubbles, plus the remaining IDROP cycles if a fetch was outstanding.
- Simultaneous branch and D-stall: the D-stall wins. The branch is re-evaluated when the stall releases because E/M is held.
- Reset mid-IDROP: the state returns to RUN and the pending wrong-path word is not discarded by this block. Memory is reset by the same reset.

## Test plan
- Reset: assert reset mid-IWAIT → outputs 0 immediately. After release with imem_ready=1: all write_*=1, pc_write=1, counters 0.
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5 → one cycle of pc_write=0, write_fd=0, flush_de=1; stall_cycles=1. Repeat with ex_rd=0 → no stall.
- D-stall: m_mem_req=1, dmem_ready=0 for 4 cycles while m_take_branch=1 → write_fd/de/em=0, flush_mw=1 for 4 cycles, no flush. Cycle 5 (dmem_ready=1) → branch flush, flush_count=1, stall_cycles=4.
- Fetch wait: imem_ready=0 for 3 cycles → state IWAIT, flush_fd=1, pc_write=0. imem_ready=1 → RUN, normal advance.
- Wrong-path drop: imem_ready=0 and m_take_branch=1 → pc_sel_branch=1, pc_write=1, IDROP. Next 2 cycles imem_ready=0, then 1 → bubble into F/D each cycle, then RUN. stall_cycles=3.
- Counter wrap: preload via 2^32 stall cycles in simulation, or force the counter to 0xFFFFFFFF → next stall gives 0.
